ntt_butterfly_unit: RTL and testbench
=====================================

# ntt_butterfly_unit

Parametrised, fully pipelined radix-2 butterfly for the NTT datapath. It supports Cooley-Tukey (forward NTT) and Gentleman-Sande (inverse NTT) operation, selected per sample. Modular reduction uses Barrett reduction with a constant derived from the `Q` parameter. The unit accepts one butterfly per cycle, has a fixed latency in both modes, and carries a sideband tag so the stage controller can place results back into memory.

## Interface
- `W`, 30: coefficient width in bits; 4 ≤ W ≤ 31.
- `Q`, 998244353: modulus; must satisfy 2^(W-1) < Q < 2^W.
- `TAG_W`, 8: width of the sideband tag.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: input sample present this cycle.
- `in_mode` input 1: 0 = CT, 1 = GS.
- `in_a`, `in_b`, `in_w` input W each: operands and twiddle; each must be < Q, otherwise outputs are undefined.
- `in_tag` input TAG_W: passed through, aligned with the data.
- `out_valid` output 1: result present this cycle.
- `out_A`, `out_B` output W each: results, always in [0, Q).
- `out_tag` output TAG_W: tag of the sample on the outputs.

## Operation
- Mode CT:
  - A = (a + w·b) mod Q
  - B = (a − w·b) mod Q
- Mode GS:
  - A = (a + b) mod Q
  - B = ((a − b)·w) mod Q
- Mode and tag travel down the pipeline with their sample. Mixed modes in consecutive cycles are legal.
- The pipeline has no backpressure. It runs every cycle, and bubbles (`in_valid` = 0) propagate as `out_valid` = 0.
- Stage S1: register a, b, w, mode, tag and valid.
- Stage S2 (pre add/sub):
  - GS: x = (a+b) mod Q and y = (a−b) mod Q.
  - CT: x = a and y = b.
  - Add: compute the sum in W+1 bits, then subtract Q once if ≥ Q.
  - Subtract: add Q if the raw difference is negative.
- Stage S3: p = w·y as a full 2W-bit product; x is delayed alongside.
- Stage S4: q̂ = ((p >> (W−1)) · M) >> (W+1).
  - M is a localparam computed as floor(2^(2W) / Q) using 64-bit constant arithmetic.
- Stage S5: r = p − q̂·Q, computed in W+2 bits. r < 3Q, so apply up to two conditional subtractions of Q to give m in [0, Q).
- Stage S6 (post add/sub):
  - CT: A = (x+m) mod Q and B = (x−m) mod Q.
  - GS: A = x and B = m.
  - Halving, if configured, is applied here. Results are registered onto the outputs.
- Reset behaviour:
  - All valid bits, data registers and outputs are cleared to 0 while `rst` is high.
  - `out_valid`, `out_A`, `out_B` and `out_tag` all read 0 during reset.
  - Asserting reset mid-operation discards every in-flight sample; nothing in flight is emitted after release.

## Timing
- Latency is exactly 6 cycles in both modes, with or without halving. A sample captured at rising edge N appears with `out_valid` = 1 after edge N+6.
- Throughput is 1 butterfly per cycle. Back-to-back samples emerge back-to-back, in order, with their tags.
- Outputs hold their last values when `out_valid` = 0. Consumers must qualify the data with `out_valid`.
- The first sample may be presented in the cycle after `rst` deasserts.

## Configuration
- `NTT_BUTTERFLY_HALVE_EN` defined:
  - In GS mode, both A and B are multiplied by 2⁻¹ mod Q in S6: v even → v>>1; v odd → (v+Q)>>1, computed in W+1 bits.
  - This folds the INTT 1/N scaling into the log2(N) stages. CT mode is unaffected.
- `NTT_BUTTERFLY_HALVE_EN` undefined: no halving logic is synthesised; GS outputs are unscaled.

## Test plan
- CT, W=4, Q=13, a=5, b=7, w=3, tag=0x11 → 6 cycles later: A=0, B=10, tag=0x11, `out_valid` high for exactly 1 cycle.
- GS, W=4, Q=13, a=5, b=7, w=3:
  - Macro undefined → A=12, B=7.
  - With `NTT_BUTTERFLY_HALVE_EN` → A=6, B=10.
- Boundary, W=4, Q=13, CT, a=b=w=12 → A=0, B=11.
- Boundary, W=4, Q=13, GS, a=0, b=12, w=12 → A=12, B=12.
- Streaming, W=30, Q=998244353: 1000 random samples with random mode, random tags and random bubbles → every output matches the reference model bit-exactly, in order, at a latency of 6.
- Reset: assert `rst` for 1 cycle while 4 samples are in flight → no `out_valid` for those samples and outputs read 0. A sample issued after release returns 6 cycles later with the correct result.

Source files
------------

// File: rtl/ntt_butterfly_unit.sv
// ntt_butterfly_unit: fully pipelined radix-2 NTT butterfly with Barrett reduction.
//   CT (in_mode=0): A = a + w*b, B = a - w*b  (mod Q)
//   GS (in_mode=1): A = a + b,   B = (a - b)*w (mod Q)
// Ports: clk, rst (async, active-high); in_valid/in_mode/in_a/in_b/in_w/in_tag in;
//        out_valid/out_A/out_B/out_tag out. Latency 6 cycles, one sample per cycle.
// Optional macro NTT_BUTTERFLY_HALVE_EN: GS results are multiplied by 2^-1 mod Q.
module ntt_butterfly_unit #(
  parameter int unsigned W     = 30,
  parameter int unsigned Q     = 998244353,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_mode,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W-1:0]     in_w,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [W-1:0]     out_A,
  output logic [W-1:0]     out_B,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [W-1:0]    QW     = W'(Q);
  localparam longint unsigned M_FULL = (64'd1 << (2 * W)) / 64'(Q);
  localparam logic [W:0]      M      = M_FULL[W:0];

  typedef enum logic {
    MODE_CT = 1'b0,
    MODE_GS = 1'b1
  } mode_e;

  typedef struct packed {
    logic             valid;
    mode_e            mode;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [W-1:0]     w;
  } s1_t;

  typedef struct packed {
    logic             valid;
    mode_e            mode;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     x;
    logic [W-1:0]     y;
    logic [W-1:0]     w;
  } s2_t;

  typedef struct packed {
    logic             valid;
    mode_e            mode;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     x;
    logic [2*W-1:0]   p;
  } s3_t;

  typedef struct packed {
    logic             valid;
    mode_e            mode;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     x;
    logic [2*W-1:0]   p;
    logic [W:0]       qhat;
  } s4_t;

  typedef struct packed {
    logic             valid;
    mode_e            mode;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     x;
    logic [W+1:0]     r;
  } s5_t;

  typedef struct packed {
    logic             valid;
    mode_e            mode;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     x;
    logic [W-1:0]     m;
  } s6_t;

  typedef struct packed {
    logic             valid;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [TAG_W-1:0] tag;
  } out_t;

  s1_t  s1_d,  s1_q;
  s2_t  s2_d,  s2_q;
  s3_t  s3_d,  s3_q;
  s4_t  s4_d,  s4_q;
  s5_t  s5_d,  s5_q;
  s6_t  s6_d,  s6_q;
  out_t out_d, out_q;

  logic [2*W+1:0] qhat_prod;
  logic [2*W+1:0] qq_prod;
  logic [W+1:0]   red;

  function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, QW}) s = s - {1'b0, QW};
    return W'(s);
  endfunction

  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[W]) d = d + {1'b0, QW};
    return W'(d);
  endfunction

`ifdef NTT_BUTTERFLY_HALVE_EN
  function automatic logic [W-1:0] halve(input logic [W-1:0] v);
    logic [W:0] t;
    t = v[0] ? ({1'b0, v} + {1'b0, QW}) : {1'b0, v};
    return W'(t >> 1);
  endfunction
`endif

  always_comb begin
    // S1: input capture
    s1_d       = '0;
    s1_d.valid = in_valid;
    s1_d.mode  = mode_e'(in_mode);
    s1_d.tag   = in_tag;
    s1_d.a     = in_a;
    s1_d.b     = in_b;
    s1_d.w     = in_w;

    // S2: pre add/sub
    s2_d       = '0;
    s2_d.valid = s1_q.valid;
    s2_d.mode  = s1_q.mode;
    s2_d.tag   = s1_q.tag;
    s2_d.w     = s1_q.w;
    if (s1_q.mode == MODE_GS) begin
      s2_d.x = add_mod(s1_q.a, s1_q.b);
      s2_d.y = sub_mod(s1_q.a, s1_q.b);
    end else begin
      s2_d.x = s1_q.a;
      s2_d.y = s1_q.b;
    end

    // S3: full product
    s3_d       = '0;
    s3_d.valid = s2_q.valid;
    s3_d.mode  = s2_q.mode;
    s3_d.tag   = s2_q.tag;
    s3_d.x     = s2_q.x;
    s3_d.p     = {{W{1'b0}}, s2_q.w} * {{W{1'b0}}, s2_q.y};

    // S4: Barrett quotient estimate
    qhat_prod  = (2*W+2)'(s3_q.p >> (W - 1)) * {{(W+1){1'b0}}, M};
    s4_d       = '0;
    s4_d.valid = s3_q.valid;
    s4_d.mode  = s3_q.mode;
    s4_d.tag   = s3_q.tag;
    s4_d.x     = s3_q.x;
    s4_d.p     = s3_q.p;
    s4_d.qhat  = (W+1)'(qhat_prod >> (W + 1));

    // S5 is split over two registers: the remainder r, then its correction
    // into [0, Q), so the output register lands 6 cycles after capture.
    qq_prod    = {{(W+1){1'b0}}, s4_q.qhat} * {{(W+2){1'b0}}, QW};
    s5_d       = '0;
    s5_d.valid = s4_q.valid;
    s5_d.mode  = s4_q.mode;
    s5_d.tag   = s4_q.tag;
    s5_d.x     = s4_q.x;
    s5_d.r     = (W+2)'(s4_q.p) - (W+2)'(qq_prod);

    red = s5_q.r;
    if (red >= {2'b00, QW}) red = red - {2'b00, QW};
    if (red >= {2'b00, QW}) red = red - {2'b00, QW};
    s6_d       = '0;
    s6_d.valid = s5_q.valid;
    s6_d.mode  = s5_q.mode;
    s6_d.tag   = s5_q.tag;
    s6_d.x     = s5_q.x;
    s6_d.m     = W'(red);

    // S6: post add/sub; output data holds while no sample arrives
    out_d       = out_q;
    out_d.valid = s6_q.valid;
    if (s6_q.valid) begin
      out_d.tag = s6_q.tag;
      if (s6_q.mode == MODE_CT) begin
        out_d.a = add_mod(s6_q.x, s6_q.m);
        out_d.b = sub_mod(s6_q.x, s6_q.m);
      end else begin
`ifdef NTT_BUTTERFLY_HALVE_EN
        out_d.a = halve(s6_q.x);
        out_d.b = halve(s6_q.m);
`else
        out_d.a = s6_q.x;
        out_d.b = s6_q.m;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      s4_q  <= '0;
      s5_q  <= '0;
      s6_q  <= '0;
      out_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
      s4_q  <= s4_d;
      s5_q  <= s5_d;
      s6_q  <= s6_d;
      out_q <= out_d;
    end
  end

  assign out_valid = out_q.valid;
  assign out_A     = out_q.a;
  assign out_B     = out_q.b;
  assign out_tag   = out_q.tag;

endmodule

// File: tb/tb_ntt_butterfly_unit.sv
// Bench for ntt_butterfly_unit: a W=4/Q=13 instance for hand-worked cases and a
// default W=30 instance for a random stream, both checked every cycle against
// a plain-arithmetic model with a 6-cycle latency.
module tb_ntt_butterfly_unit;

  localparam longint unsigned SQ = 13;
  localparam longint unsigned BQ = 998244353;
  localparam int unsigned     LAT = 7; // drive after edge k -> capture k+1 -> out after k+7

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // small instance
  logic       s_in_valid, s_in_mode;
  logic [3:0] s_in_a, s_in_b, s_in_w;
  logic [7:0] s_in_tag;
  logic       s_out_valid;
  logic [3:0] s_out_a, s_out_b;
  logic [7:0] s_out_tag;

  // big instance
  logic        b_in_valid, b_in_mode;
  logic [29:0] b_in_a, b_in_b, b_in_w;
  logic [7:0]  b_in_tag;
  logic        b_out_valid;
  logic [29:0] b_out_a, b_out_b;
  logic [7:0]  b_out_tag;

  ntt_butterfly_unit #(.W(4), .Q(13), .TAG_W(8)) u_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_mode(s_in_mode),
    .in_a(s_in_a), .in_b(s_in_b), .in_w(s_in_w), .in_tag(s_in_tag),
    .out_valid(s_out_valid), .out_A(s_out_a), .out_B(s_out_b), .out_tag(s_out_tag)
  );

  ntt_butterfly_unit #(.W(30), .Q(998244353), .TAG_W(8)) u_big (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_mode(b_in_mode),
    .in_a(b_in_a), .in_b(b_in_b), .in_w(b_in_w), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_A(b_out_a), .out_B(b_out_b), .out_tag(b_out_tag)
  );

  typedef struct {
    int unsigned     due;
    longint unsigned ea;
    longint unsigned eb;
    logic [7:0]      tag;
  } exp_t;

  exp_t sq[$];
  exp_t bq[$];
  longint unsigned s_last_a = 0, s_last_b = 0, b_last_a = 0, b_last_b = 0;
  logic [7:0]      s_last_tag = '0, b_last_tag = '0;

  function automatic longint unsigned half_mod(input longint unsigned v, input longint unsigned q);
    return (v % 2 == 0) ? v / 2 : (v + q) / 2;
  endfunction

  function automatic void ref_bf(input longint unsigned q, input bit mode,
                                 input longint unsigned a, input longint unsigned b,
                                 input longint unsigned w,
                                 output longint unsigned ra, output longint unsigned rb);
    longint unsigned t;
    if (!mode) begin
      t  = (w * b) % q;
      ra = (a + t) % q;
      rb = (a + q - t) % q;
    end else begin
      ra = (a + b) % q;
      rb = (((a + q - b) % q) * w) % q;
`ifdef NTT_BUTTERFLY_HALVE_EN
      ra = half_mod(ra, q);
      rb = half_mod(rb, q);
`endif
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_small(input bit v, input bit mode, input int unsigned a,
                             input int unsigned b, input int unsigned w, input logic [7:0] tag);
    exp_t e;
    s_in_valid = v; s_in_mode = mode;
    s_in_a = 4'(a); s_in_b = 4'(b); s_in_w = 4'(w); s_in_tag = tag;
    if (v) begin
      e.due = cyc + LAT;
      e.tag = tag;
      ref_bf(SQ, mode, a, b, w, e.ea, e.eb);
      sq.push_back(e);
    end
  endtask

  task automatic drive_big(input bit v);
    exp_t e;
    b_in_valid = v;
    b_in_mode  = 1'($urandom_range(1, 0));
    b_in_a     = 30'($urandom_range(int'(BQ - 1), 0));
    b_in_b     = 30'($urandom_range(int'(BQ - 1), 0));
    b_in_w     = 30'($urandom_range(int'(BQ - 1), 0));
    b_in_tag   = 8'($urandom_range(255, 0));
    if (v) begin
      e.due = cyc + LAT;
      e.tag = b_in_tag;
      ref_bf(BQ, b_in_mode, b_in_a, b_in_b, b_in_w, e.ea, e.eb);
      bq.push_back(e);
    end
  endtask

  // compare: small instance
  always @(negedge clk) begin
    if (rst) begin
      sq.delete();
      s_last_a = 0; s_last_b = 0; s_last_tag = '0;
      chk("s_rst_valid", s_out_valid, 0);
      chk("s_rst_A", s_out_a, 0);
      chk("s_rst_B", s_out_b, 0);
      chk("s_rst_tag", s_out_tag, 0);
    end else if (sq.size() > 0 && sq[0].due == cyc) begin
      exp_t e;
      e = sq.pop_front();
      chk("s_valid", s_out_valid, 1);
      chk("s_A", s_out_a, e.ea);
      chk("s_B", s_out_b, e.eb);
      chk("s_tag", s_out_tag, e.tag);
      s_last_a = e.ea; s_last_b = e.eb; s_last_tag = e.tag;
    end else begin
      chk("s_idle_valid", s_out_valid, 0);
      chk("s_hold_A", s_out_a, s_last_a);
      chk("s_hold_B", s_out_b, s_last_b);
      chk("s_hold_tag", s_out_tag, s_last_tag);
    end
  end

  // compare: big instance
  always @(negedge clk) begin
    if (rst) begin
      bq.delete();
      b_last_a = 0; b_last_b = 0; b_last_tag = '0;
      chk("b_rst_valid", b_out_valid, 0);
      chk("b_rst_A", b_out_a, 0);
      chk("b_rst_B", b_out_b, 0);
      chk("b_rst_tag", b_out_tag, 0);
    end else if (bq.size() > 0 && bq[0].due == cyc) begin
      exp_t e;
      e = bq.pop_front();
      chk("b_valid", b_out_valid, 1);
      chk("b_A", b_out_a, e.ea);
      chk("b_B", b_out_b, e.eb);
      chk("b_tag", b_out_tag, e.tag);
      b_last_a = e.ea; b_last_b = e.eb; b_last_tag = e.tag;
    end else begin
      chk("b_idle_valid", b_out_valid, 0);
      chk("b_hold_A", b_out_a, b_last_a);
      chk("b_hold_B", b_out_b, b_last_b);
      chk("b_hold_tag", b_out_tag, b_last_tag);
    end
  end

  initial begin
    longint unsigned ra, rb;
    int unsigned n;
    bit did_rst;

    s_in_valid = 0; s_in_mode = 0; s_in_a = '0; s_in_b = '0; s_in_w = '0; s_in_tag = '0;
    b_in_valid = 0; b_in_mode = 0; b_in_a = '0; b_in_b = '0; b_in_w = '0; b_in_tag = '0;

    // hand-computed values pinning the model
    ref_bf(SQ, 0, 5, 7, 3, ra, rb);
    chk("pin_ct_A", ra, 0);
    chk("pin_ct_B", rb, 10);
    ref_bf(SQ, 0, 12, 12, 12, ra, rb);
    chk("pin_ct_edge_A", ra, 0);
    chk("pin_ct_edge_B", rb, 11);
    ref_bf(SQ, 1, 5, 7, 3, ra, rb);
`ifdef NTT_BUTTERFLY_HALVE_EN
    chk("pin_gs_A", ra, 6);
    chk("pin_gs_B", rb, 10);
`else
    chk("pin_gs_A", ra, 12);
    chk("pin_gs_B", rb, 7);
`endif
    ref_bf(SQ, 1, 0, 12, 12, ra, rb);
`ifdef NTT_BUTTERFLY_HALVE_EN
    chk("pin_gs_edge_A", ra, 6);
    chk("pin_gs_edge_B", rb, 6);
`else
    chk("pin_gs_edge_A", ra, 12);
    chk("pin_gs_edge_B", rb, 12);
`endif

    repeat (3) @(posedge clk);
    #1 rst = 0;

    // directed cases on the W=4 instance
    drive_small(1, 0, 5, 7, 3, 8'h11);
    @(posedge clk); #1 drive_small(0, 0, 0, 0, 0, 8'h00);
    repeat (8) begin @(posedge clk); #1; end
    drive_small(1, 1, 5, 7, 3, 8'h22);
    @(posedge clk); #1 drive_small(1, 0, 12, 12, 12, 8'h33);
    @(posedge clk); #1 drive_small(1, 1, 0, 12, 12, 8'h44);
    @(posedge clk); #1 drive_small(0, 1, 3, 3, 3, 8'h55);
    for (int unsigned i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      drive_small(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                  $urandom_range(12, 0), $urandom_range(12, 0), $urandom_range(12, 0),
                  8'($urandom_range(255, 0)));
    end
    @(posedge clk); #1 drive_small(0, 0, 0, 0, 0, 8'h00);

    // random stream on the W=30 instance, with a mid-flight reset
    n = 0;
    did_rst = 0;
    while (n < 1000) begin
      @(posedge clk); #1;
      if (n >= 500 && !did_rst) begin
        did_rst = 1;
        drive_big(1);
        for (int unsigned k = 0; k < 3; k++) begin
          @(posedge clk); #1 drive_big(1);
        end
        @(posedge clk); #1;
        drive_big(0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        drive_big(1);
        @(posedge clk); #1 drive_big(0);
        repeat (8) begin @(posedge clk); #1; end
        n += 5;
      end else begin
        bit v;
        v = ($urandom_range(3, 0) != 0);
        drive_big(v);
        if (v) n++;
      end
    end
    @(posedge clk); #1 drive_big(0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("s_drained", sq.size(), 0);
    chk("b_drained", bq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
